rng_nibble_packer: RTL

Downstream stage of the pseudorandom number generator FSM. Collects the generator's 4-bit samples and packs three consecutive nibbles, MSB first, into a 12-bit word. Buffers completed words in a small synchronous FIFO with a valid/ready output. Returns the last completed word on `prev` as the generator's feedback operand.

---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_word_fifo.sv | 61 ++++++
 rtl/rng_nibble_packer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared constants and types for the pseudorandom generator and its downstream packer.
// WORD_W also sizes the generator's seed/prev ports, so keep the two in step.
package rng_pkg;

    localparam int NIB_W         = 4;
    localparam int WORD_W        = 12;
    localparam int NIBS_PER_WORD = 3;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;

    // Number of nibbles currently held by the assembler
    typedef enum logic [1:0] {
        S0,
        S1,
        S2
    } pack_state_t;

endpackage

// File: rtl/rng_word_fifo.sv
// Small synchronous first-word-fall-through FIFO of packed words.
// The head entry is visible on rdata whenever the FIFO is not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module rng_word_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  word_t                  wdata,
    input  logic                   pop,
    output word_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    word_t          mem_q [DEPTH];
    logic [AW-1:0]  wrPtr_q;
    logic [AW-1:0]  rdPtr_q;
    logic [AW:0]    level_q;
    logic           doPop;
    logic           doPush;

    assign empty  = (level_q == '0);
    assign full   = (level_q == (AW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdata  = mem_q[rdPtr_q];
    assign level  = level_q;

    // Storage, pointers and occupancy; reset wipes the contents so the head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rng_nibble_packer.sv
// Packs three generator nibbles (MSB first) into a 12-bit word and queues it in a FWFT FIFO.
// prev returns the last completed word to the generator, even when the FIFO had to drop it.
// Build option RNG_PACK_STATS_EN: when defined, drop_cnt is a live saturating drop counter;
// otherwise drop_cnt is tied to zero.
module rng_nibble_packer
    import rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  nib_t                   in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output word_t                  out_data,
    output word_t                  prev,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    pack_state_t state_q;
    pack_state_t state_d;
    word_t       acc_q;
    word_t       acc_d;
    word_t       prev_q;
    logic        overflow_q;
    logic        wordDone;
    word_t       doneWord;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        fifoPop;
    logic        fifoPush;
    logic        wordDrop;

    // Assembler next state: place the incoming nibble first, then let flush close whatever is held
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wordDone = 1'b0;
        doneWord = acc_q;
        unique case (state_q)
            S0: begin
                if (in_valid) begin
                    if (flush) begin
                        wordDone = 1'b1;
                        doneWord = {in_data, 8'h00};
                        acc_d    = '0;
                        state_d  = S0;
                    end else begin
                        acc_d   = {in_data, 8'h00};
                        state_d = S1;
                    end
                end
            end
            S1: begin
                if (in_valid) begin
                    if (flush) begin
                        wordDone = 1'b1;
                        doneWord = {acc_q[11:8], in_data, 4'h0};
                        acc_d    = '0;
                        state_d  = S0;
                    end else begin
                        acc_d   = {acc_q[11:8], in_data, 4'h0};
                        state_d = S2;
                    end
                end else if (flush) begin
                    wordDone = 1'b1;
                    doneWord = {acc_q[11:8], 8'h00};
                    acc_d    = '0;
                    state_d  = S0;
                end
            end
            S2: begin
                if (in_valid || flush) begin
                    wordDone = 1'b1;
                    doneWord = {acc_q[11:4], (in_valid ? in_data : 4'h0)};
                    acc_d    = '0;
                    state_d  = S0;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = S0;
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take the new word
    assign fifoPop  = !fifoEmpty && out_ready;
    assign fifoPush = wordDone && (!fifoFull || fifoPop);
    assign wordDrop = wordDone && !fifoPush;

    // Assembler registers plus the feedback word and the sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S0;
            acc_q      <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (wordDone) begin
                prev_q <= doneWord;
            end
            if (wordDrop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    rng_word_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .wdata (doneWord),
        .pop   (fifoPop),
        .rdata (out_data),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (level)
    );

`ifdef RNG_PACK_STATS_EN
    logic [7:0] dropCnt_q;

    // Count dropped words, holding at 255 rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            dropCnt_q <= '0;
        end else if (wordDrop && (dropCnt_q != 8'hFF)) begin
            dropCnt_q <= dropCnt_q + 1'b1;
        end
    end

    assign drop_cnt = dropCnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign out_valid = !fifoEmpty;
    assign prev      = prev_q;
    assign overflow  = overflow_q;

endmodule
